muxn_rr: RTL and testbench
==========================

// Module: muxn_rr
// PURPOSE
//  N-channel, Width-bit registered multiplexer with round-robin arbitration and
//  valid/ready handshakes; successor to the static 4-way select mux.
//  Merges requests from several producers (e.g. I-fetch, D-mem, DMA) onto one
//  shared consumer port, tagging each beat with its source channel index.
// PARAMETERS
//  Width = 32  data width per channel
//  N     = 4   number of input channels, N >= 2
//  IdxW  = 2   index width, ceil(log2(N)); must satisfy 2**IdxW >= N
// PORTS
//  clk      in   1        single clock, rising edge
//  reset    in   1        synchronous, active-high
//  i_valid  in   N        channel k presents a beat
//  i_data   in   N*Width  channel k data at [k*Width +: Width]
//  i_ready  out  N        channel k beat accepted this cycle (one-hot or zero)
//  o_valid  out  1        output register holds a beat
//  o_data   out  Width    output beat data
//  o_sel    out  IdxW     source channel of o_data
//  o_ready  in   1        consumer accepts the beat
// BEHAVIOUR
//  - Reset (sampled at clk edge): o_valid=0, o_data=0, o_sel=0, last=N-1
//    (channel 0 wins first); i_ready=0 while reset is high.
//  - load = ~o_valid | o_ready. Arbitration happens only when load=1.
//  - Grant: first k with i_valid[k]=1, scanning (last+1) mod N upward with wrap.
//    i_ready = onehot(grant) & {N{load}}; zero if no channel is valid.
//  - On grant: o_data<=i_data[grant], o_sel<=grant, o_valid<=1, last<=grant.
//  - load=1 and no valid input: o_valid<=0; o_data/o_sel hold their values.
//  - o_valid=1 & o_ready=0: o_data, o_sel, o_valid stable; i_ready=0.
//  - Latency 1 cycle input->output; throughput 1 beat/cycle (same-cycle drain+refill).
//  - last updates only on an accepted beat; idle cycles keep the pointer.
//  - Fairness: a continuously valid channel is granted within N accepted beats.
//  - Producers hold i_valid/i_data until i_ready; dropping i_valid early is legal
//    and only forfeits that channel's turn.
//  - Reset mid-transfer: a pending output beat is discarded, nothing accepted
//    that cycle.
// CONFIGURATION
//  MUXN_FORCE_SEL_EN defined: extra ports force_en (in,1), force_sel (in,IdxW).
//    force_en=1: grant only channel force_sel (static mux mode), if it is valid
//    and force_sel < N; other channels get i_ready=0; last is not updated.
//    force_sel >= N with force_en=1: no grant.
//  Undefined: ports absent; round-robin only.
// STRUCTURE
//  - mux_defs.vh: shared header with the MUX_IDXW(n) width macro and default
//    Width/N constants, also used by the existing fixed muxes.
//  - Sub-module rr_arbiter (N, IdxW): in req[N], last, en; out gnt_onehot,
//    gnt_idx, gnt_any. Purely combinational. Wrap via double-width rotated mask.
//  - muxn_rr holds the output register, pointer, data select (AND-OR on one-hot)
//    and the force logic.
// TESTING
//  1 reset: hold reset 3 cycles with all i_valid=1 -> i_ready=0, o_valid=0, o_data=0, o_sel=0.
//  2 RR: N=4, all valid, o_ready=1, data k=0x100+k -> o_sel 0,1,2,3,0; o_data 0x100..0x103,0x100.
//  3 backpressure: o_ready=0 for 5 cycles with beat 0xAA from ch2 -> o_data=0xAA and
//    o_sel=2 stable, i_ready=0; release -> next beat from ch3.
//  4 sparse/wrap: only ch3 and ch1 valid, last=3 -> grants 1,3,1; idle cycle leaves last.
//  5 reset mid-op: o_valid=1, o_ready=0, assert reset 1 cycle -> o_valid=0, next grant ch0.
//  6 force (MUXN_FORCE_SEL_EN): force_en=1, force_sel=2, all valid -> only ch2 granted
//    each cycle; force_sel=5 (N=4) -> no grants; force_en=0 -> RR resumes from prior last.

Source files
------------

// File: rtl/muxn_rr_pkg.sv
// Shared definitions for the round-robin multiplexer family: default
// data width / channel count and the index-width helper used to size
// channel indices from a channel count.
package muxn_rr_pkg;

  localparam int MUX_WIDTH_DEF = 32;
  localparam int MUX_N_DEF     = 4;

  // Number of bits needed to index n channels (at least one bit).
  function automatic int mux_idxw(input int n);
    int w;
    w = 1;
    if (n > 2) begin
      w = $clog2(n);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Scans requests starting just after
// the last winner, wrapping around, by searching the lowest set bit of a
// double-width vector {req, req & above_last}. The upper half supplies
// the wrapped candidates when nothing above the pointer is requesting.
module rr_arbiter
  import muxn_rr_pkg::*;
#(
  parameter int N    = MUX_N_DEF,
  parameter int IdxW = mux_idxw(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] last,
  input  logic            en,
  output logic [N-1:0]    gnt_onehot,
  output logic [IdxW-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [N-1:0]   mask_s;
  logic [2*N-1:0] dbl_s;
  logic           found_s;
  logic [IdxW:0]  pos_s;

  // Mask of channels strictly after the previous winner.
  always_comb begin
    mask_s = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      mask_s[k] = (k > int'(last));
    end
  end

  // Lowest set bit of the double-width rotated request vector.
  always_comb begin
    dbl_s   = {req, req & mask_s};
    found_s = 1'b0;
    pos_s   = {(IdxW+1){1'b0}};
    for (int i = 2*N-1; i >= 0; i--) begin
      pos_s   = dbl_s[i] ? (IdxW+1)'(i) : pos_s;
      found_s = found_s | dbl_s[i];
    end
  end

  // Fold the position back into channel range and gate with enable.
  always_comb begin
    gnt_idx    = {IdxW{1'b0}};
    gnt_onehot = {N{1'b0}};
    gnt_any    = 1'b0;
    if (en && found_s) begin
      if (int'(pos_s) >= N) begin
        gnt_idx = IdxW'(int'(pos_s) - N);
      end else begin
        gnt_idx = IdxW'(pos_s);
      end
      gnt_onehot = {{(N-1){1'b0}}, 1'b1} << gnt_idx;
      gnt_any    = 1'b1;
    end else begin
      gnt_any = 1'b0;
    end
  end

endmodule

// File: rtl/muxn_rr.sv
// N-channel registered multiplexer with round-robin arbitration and
// valid/ready handshakes. Each output beat carries its source channel.
// Optional static-select mode is compiled in with MUXN_FORCE_SEL_EN,
// which adds force_en / force_sel ports.
module muxn_rr
  import muxn_rr_pkg::*;
#(
  parameter int Width = MUX_WIDTH_DEF,
  parameter int N     = MUX_N_DEF,
  parameter int IdxW  = mux_idxw(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     i_valid,
  input  logic [N*Width-1:0] i_data,
  output logic [N-1:0]     i_ready,
  output logic             o_valid,
  output logic [Width-1:0] o_data,
  output logic [IdxW-1:0]  o_sel,
  input  logic             o_ready
`ifdef MUXN_FORCE_SEL_EN
  ,
  input  logic             force_en,
  input  logic [IdxW-1:0]  force_sel
`endif
);

  logic             load_s;
  logic             arb_en_s;
  logic [N-1:0]     req_s;
  logic             upd_last_s;
  logic [N-1:0]     gnt_onehot_s;
  logic [IdxW-1:0]  gnt_idx_s;
  logic             gnt_any_s;
  logic [Width-1:0] sel_data_s;

  logic             o_valid_q, o_valid_d;
  logic [Width-1:0] o_data_q,  o_data_d;
  logic [IdxW-1:0]  o_sel_q,   o_sel_d;
  logic [IdxW-1:0]  last_q,    last_d;

  // Output register can take a new beat when empty or being drained.
  always_comb begin
    load_s   = ~o_valid_q | o_ready;
    arb_en_s = load_s & ~reset;
  end

  // Request filter: in forced mode only the selected channel may compete
  // and the round-robin pointer is frozen.
  always_comb begin
    req_s      = i_valid;
    upd_last_s = 1'b1;
`ifdef MUXN_FORCE_SEL_EN
    if (force_en) begin
      upd_last_s = 1'b0;
      if (int'(force_sel) < N) begin
        req_s = i_valid & ({{(N-1){1'b0}}, 1'b1} << force_sel);
      end else begin
        req_s = {N{1'b0}};
      end
    end else begin
      req_s      = i_valid;
      upd_last_s = 1'b1;
    end
`endif
  end

  rr_arbiter #(
    .N    (N),
    .IdxW (IdxW)
  ) u_arb (
    .req        (req_s),
    .last       (last_q),
    .en         (arb_en_s),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .gnt_any    (gnt_any_s)
  );

  // AND-OR data select on the one-hot grant.
  always_comb begin
    sel_data_s = {Width{1'b0}};
    for (int k = 0; k < N; k++) begin
      sel_data_s = sel_data_s | (i_data[k*Width +: Width] & {Width{gnt_onehot_s[k]}});
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_sel_d   = o_sel_q;
    last_d    = last_q;
    if (load_s) begin
      if (gnt_any_s) begin
        o_valid_d = 1'b1;
        o_data_d  = sel_data_s;
        o_sel_d   = gnt_idx_s;
        last_d    = upd_last_s ? gnt_idx_s : last_q;
      end else begin
        o_valid_d = 1'b0;
      end
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  // State registers; reset drops any pending beat and aims at channel 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid_q <= 1'b0;
      o_data_q  <= {Width{1'b0}};
      o_sel_q   <= {IdxW{1'b0}};
      last_q    <= IdxW'(N - 1);
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_sel_q   <= o_sel_d;
      last_q    <= last_d;
    end
  end

  assign i_ready = gnt_onehot_s;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_sel   = o_sel_q;

endmodule

// File: tb/tb_muxn_rr.sv
// Directed testbench for muxn_rr (N=4, Width=32). With MUXN_FORCE_SEL_EN
// the index width is widened to 3 so an out-of-range force_sel can be driven.
module tb_muxn_rr;

  localparam int W = 32;
  localparam int N = 4;
`ifdef MUXN_FORCE_SEL_EN
  localparam int IW = 3;
`else
  localparam int IW = 2;
`endif

  logic           clk;
  logic           reset;
  logic [N-1:0]   i_valid;
  logic [N*W-1:0] i_data;
  logic [N-1:0]   i_ready;
  logic           o_valid;
  logic [W-1:0]   o_data;
  logic [IW-1:0]  o_sel;
  logic           o_ready;
`ifdef MUXN_FORCE_SEL_EN
  logic           force_en;
  logic [IW-1:0]  force_sel;
`endif

  int total;
  int bad;

  muxn_rr #(.Width(W), .N(N), .IdxW(IW)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_sel   (o_sel),
    .o_ready (o_ready)
`ifdef MUXN_FORCE_SEL_EN
    ,
    .force_en  (force_en),
    .force_sel (force_sel)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check combinational ready shortly after inputs settle.
  task automatic chk_rdy(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, 32'(i_ready), 32'(exp));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input int s);
    chk({tag, ".valid"}, 32'(o_valid), 32'(v));
    chk({tag, ".data"}, o_data, d);
    chk({tag, ".sel"}, 32'(o_sel), 32'(s));
  endtask

  task automatic set_data(input int k, input logic [31:0] v);
    i_data[k*W +: W] = v;
  endtask

  initial begin
    logic [3:0] e;
    total = 0;
    bad   = 0;
    reset   = 1'b1;
    i_valid = 4'hF;
    i_data  = '0;
    o_ready = 1'b1;
`ifdef MUXN_FORCE_SEL_EN
    force_en  = 1'b0;
    force_sel = '0;
`endif
    for (int k = 0; k < N; k++) set_data(k, 32'h100 + 32'(k));

    // 1: reset held with all inputs valid
    for (int c = 0; c < 3; c++) begin
      chk_rdy("rst.ready", 4'b0000);
      tick();
      chk_out("rst", 1'b0, 32'h0, 0);
    end
    reset = 1'b0;

    // 2: full round robin, channel 0 first
    for (int i = 0; i < 5; i++) begin
      e = 4'b0001 << (i % 4);
      chk_rdy("rr.ready", e);
      tick();
      chk_out("rr", 1'b1, 32'h100 + 32'(i % 4), i % 4);
    end

    // 3: backpressure on a beat from channel 2
    chk_rdy("bp.pre_ready", 4'b0010);
    tick();
    chk_out("bp.pre", 1'b1, 32'h101, 1);
    set_data(2, 32'hAA);
    chk_rdy("bp.load_ready", 4'b0100);
    tick();
    chk_out("bp.load", 1'b1, 32'hAA, 2);
    o_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk_rdy("bp.stall_ready", 4'b0000);
      tick();
      chk_out("bp.stall", 1'b1, 32'hAA, 2);
    end
    set_data(2, 32'h102);
    o_ready = 1'b1;
    chk_rdy("bp.rel_ready", 4'b1000);
    tick();
    chk_out("bp.rel", 1'b1, 32'h103, 3);

    // 4: sparse requests with wrap, then idle keeps the pointer
    i_valid = 4'b1010;
    chk_rdy("sp.r1", 4'b0010);
    tick();
    chk_out("sp.b1", 1'b1, 32'h101, 1);
    chk_rdy("sp.r3", 4'b1000);
    tick();
    chk_out("sp.b3", 1'b1, 32'h103, 3);
    chk_rdy("sp.r1b", 4'b0010);
    tick();
    chk_out("sp.b1b", 1'b1, 32'h101, 1);
    i_valid = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      chk_rdy("idle.ready", 4'b0000);
      tick();
      chk_out("idle", 1'b0, 32'h101, 1);
    end
    i_valid = 4'hF;
    chk_rdy("idle.resume_ready", 4'b0100);
    tick();
    chk_out("idle.resume", 1'b1, 32'h102, 2);

    // 5: reset while a beat is stalled in the output register
    o_ready = 1'b0;
    chk_rdy("mr.stall_ready", 4'b0000);
    tick();
    chk_out("mr.stall", 1'b1, 32'h102, 2);
    reset = 1'b1;
    chk_rdy("mr.rst_ready", 4'b0000);
    tick();
    chk_out("mr.rst", 1'b0, 32'h0, 0);
    reset   = 1'b0;
    o_ready = 1'b1;
    chk_rdy("mr.first_ready", 4'b0001);
    tick();
    chk_out("mr.first", 1'b1, 32'h100, 0);

`ifdef MUXN_FORCE_SEL_EN
    // 6: forced static selection, out-of-range select, then RR resumes
    force_en  = 1'b1;
    force_sel = 3'd2;
    for (int c = 0; c < 3; c++) begin
      chk_rdy("fs.ready", 4'b0100);
      tick();
      chk_out("fs", 1'b1, 32'h102, 2);
    end
    force_sel = 3'd5;
    for (int c = 0; c < 2; c++) begin
      chk_rdy("fs.oor_ready", 4'b0000);
      tick();
      chk_out("fs.oor", 1'b0, 32'h102, 2);
    end
    force_en = 1'b0;
    chk_rdy("fs.resume_ready", 4'b0010);
    tick();
    chk_out("fs.resume", 1'b1, 32'h101, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
